// File: rtl/cell_write_allocator_pkg.sv
// Shared switch types for the cell buffer write path.
// Widths here must match the allocator's parameters.
package genericSwitchPkg;

  localparam int numPorts = 4;
  localparam int numAddresses = 32;
  localparam int addrWidth = $clog2(numAddresses);
  localparam int portWidth = (numPorts > 1) ? $clog2(numPorts) : 1;

  typedef struct packed {
    logic startOfFrame;
    logic endOfFrame;
  } info_type;

  typedef struct packed {
    logic [portWidth-1:0] port;
    logic [addrWidth-1:0] address;
    info_type info;
  } cell_queue_type;

  typedef logic [addrWidth:0] free_fifo_count_type;

  // Idle arbiter value: the first search after reset starts at port 0.
  localparam logic [portWidth-1:0] NO_PORT = portWidth'(numPorts - 1);

endpackage

// File: rtl/cell_write_allocator_fifo.sv
// Free buffer address list: synchronous FIFO.
// Push is dropped while full; pop is ignored while empty.
module free_address_fifo #(
  parameter int depth = 32,
  parameter int width = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [width-1:0] pushData,
  input  logic             pop,
  output logic [width-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [width:0]   count
);

  logic [width-1:0] mem [depth];
  logic [width-1:0] wrPtr;
  logic [width-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [width-1:0] nextPtr(input logic [width-1:0] p);
    return (p == width'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (width + 1)'(depth));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop) rdPtr <= nextPtr(rdPtr);
      unique case (1'b1)
        doPush && !doPop: count <= count + 1'b1;
        doPop && !doPush: count <= count - 1'b1;
        default:          count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cell_write_allocator.sv
// Write side of the shared cell buffer: arbitration, address allocation, linking.
// Optional per-port statistics under `CELL_WRITER_STATS_EN.
module cell_write_allocator
  import genericSwitchPkg::*;
#(
  parameter int nbrOfPorts = numPorts,
  parameter int addresses = numAddresses,
  parameter int parrallelWidth = 512,
  parameter int addressWidth = $clog2(addresses)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [nbrOfPorts-1:0]                cellValid,
  input  logic [nbrOfPorts*parrallelWidth-1:0] cellData,
  input  info_type                             cellInfo [nbrOfPorts],
  output logic [nbrOfPorts-1:0]                cellReady,
  input  logic                                 freeEnable,
  input  logic [addressWidth-1:0]              freeAddress,
  output logic                                 memWriteEnable,
  output logic [addressWidth-1:0]              memWriteAddress,
  output logic [parrallelWidth-1:0]            memWriteData,
  output info_type                             memWriteInfo,
  output logic                                 linkWriteEnable,
  output logic [addressWidth-1:0]              linkWriteAddress,
  output logic [addressWidth-1:0]              linkWriteData,
  output logic                                 wroteCell,
  output cell_queue_type                       writtenCell,
  output logic                                 initDone,
  output logic                                 freeOverflow,
  output logic                                 protocolError
`ifdef CELL_WRITER_STATS_EN
  ,
  output logic [31:0]                          cellCount [nbrOfPorts],
  output free_fifo_count_type                  minFreeLevel
`endif
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                state;
  logic [addressWidth-1:0]   initCnt;
  logic                      initLast;
  logic [portWidth-1:0]      lastPort;
  logic [portWidth-1:0]      grantPort;
  logic                      transfer;
  int                        cand;
  logic [nbrOfPorts-1:0]     inFrame;
  logic [addressWidth-1:0]   prevAddr [nbrOfPorts];
  info_type                  grantInfo;
  logic [parrallelWidth-1:0] grantData;

  logic                      fifoPush;
  logic [addressWidth-1:0]   fifoPushData;
  logic [addressWidth-1:0]   fifoHead;
  logic                      fifoFull;
  logic                      fifoEmpty;
  free_fifo_count_type       fifoCount;

  assign initLast = (initCnt == addressWidth'(addresses - 1));

  // INIT seeds every address; afterwards only the read path refills.
  assign fifoPush     = (state == INIT) ? 1'b1 : freeEnable;
  assign fifoPushData = (state == INIT) ? initCnt : freeAddress;

  free_address_fifo #(
    .depth (addresses),
    .width (addressWidth)
  ) u_freeList (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fifoPush),
    .pushData (fifoPushData),
    .pop      (transfer),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_comb begin
    cellReady = '0;
    grantPort = lastPort;
    transfer  = 1'b0;
    cand      = 0;
    if (state == RUN && !fifoEmpty) begin
      for (int k = 1; k <= nbrOfPorts; k++) begin
        cand = (int'(lastPort) + k) % nbrOfPorts;
        if (!transfer && cellValid[cand]) begin
          cellReady[cand] = 1'b1;
          grantPort       = portWidth'(cand);
          transfer        = 1'b1;
        end
      end
    end
  end

  assign grantInfo = cellInfo[grantPort];
  assign grantData = cellData[int'(grantPort)*parrallelWidth +: parrallelWidth];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= INIT;
      initCnt          <= '0;
      initDone         <= 1'b0;
      lastPort         <= NO_PORT;
      inFrame          <= '0;
      for (int i = 0; i < nbrOfPorts; i++) prevAddr[i] <= '0;
      memWriteEnable   <= 1'b0;
      memWriteAddress  <= '0;
      memWriteData     <= '0;
      memWriteInfo     <= '0;
      linkWriteEnable  <= 1'b0;
      linkWriteAddress <= '0;
      linkWriteData    <= '0;
      wroteCell        <= 1'b0;
      writtenCell      <= '0;
      freeOverflow     <= 1'b0;
      protocolError    <= 1'b0;
    end else begin
      memWriteEnable  <= 1'b0;
      linkWriteEnable <= 1'b0;
      wroteCell       <= 1'b0;
      unique case (1'b1)
        state == INIT: begin
          initCnt <= initCnt + 1'b1;
          if (initLast) begin
            state    <= RUN;
            initDone <= 1'b1;
          end
        end
        state == RUN: begin
          if (freeEnable && fifoFull) freeOverflow <= 1'b1;
        end
      endcase
      if (transfer) begin
        memWriteEnable        <= 1'b1;
        memWriteAddress       <= fifoHead;
        memWriteData          <= grantData;
        memWriteInfo          <= grantInfo;
        wroteCell             <= 1'b1;
        writtenCell.port      <= grantPort;
        writtenCell.address   <= fifoHead;
        writtenCell.info      <= grantInfo;
        lastPort              <= grantPort;
        prevAddr[grantPort]   <= fifoHead;
        if (!grantInfo.startOfFrame) begin
          if (inFrame[grantPort]) begin
            linkWriteEnable  <= 1'b1;
            linkWriteAddress <= prevAddr[grantPort];
            linkWriteData    <= fifoHead;
          end else begin
            protocolError <= 1'b1;
          end
        end
        // A fresh SOF abandons any open frame on that port.
        if (grantInfo.startOfFrame)
          inFrame[grantPort] <= !grantInfo.endOfFrame;
        else if (grantInfo.endOfFrame)
          inFrame[grantPort] <= 1'b0;
      end
    end
  end

`ifdef CELL_WRITER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < nbrOfPorts; i++) cellCount[i] <= '0;
      minFreeLevel <= '0;
    end else begin
      if (transfer) cellCount[grantPort] <= cellCount[grantPort] + 32'd1;
      if (state == INIT && initLast)
        minFreeLevel <= (addressWidth + 1)'(addresses);
      else if (state == RUN && fifoCount < minFreeLevel)
        minFreeLevel <= fifoCount;
    end
  end
`endif

endmodule
